jit_pipeline_elastic: RTL and testbench

Parametrised successor to the fixed 3-stage enable-driven vector pipeline. Computes a selectable ALU result on two WIDTH-bit operands. Packs {tag, data, lo} into one bus and carries it through DEPTH elastic stages with valid/ready handshakes. Stages collapse bubbles and support a synchronous flush. Sits between an operand producer and a consumer that may stall.

---
 rtl/jit_pipeline_elastic.sv | 111 +++++++++++
 tb/tb_jit_pipeline_elastic.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jit_pipeline_elastic.sv
// Elastic DEPTH-stage ALU pipeline with valid/ready handshakes and flush.
// Define JIT_PIPE_OCC_EN to add the occ port (count of occupied stages).
module jit_pipeline_elastic #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int LO_W  = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_tag,
  output logic [WIDTH-1:0] out_data,
  output logic [LO_W-1:0]  out_lo
`ifdef JIT_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  localparam int BW = 1 + WIDTH + LO_W;

  logic [WIDTH-1:0] res;
  logic [BW-1:0]    bus_in;

  always_comb begin
    res = '0;
    unique case (in_op)
      2'd0: res = in_a + in_b;
      2'd1: res = in_a ^ in_b;
      2'd2: res = in_a - in_b;
      2'd3: res = in_a & in_b;
      default: res = '0;
    endcase
  end

  assign bus_in = {in_a == in_b, res, res[LO_W-1:0]};

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [BW-1:0]    bus_q [DEPTH];
  logic [BW-1:0]    bus_d [DEPTH];
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] up_v;
  logic [BW-1:0]    up_bus [DEPTH];

  // A stage may take a beat if any stage at or after it is empty,
  // or the consumer is draining the tail.
  always_comb begin
    logic a;
    a   = out_ready;
    acc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a      = !valid_q[i] | a;
      acc[i] = a;
    end
  end

  assign in_ready = acc[0] & !flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_up
    if (g == 0) begin : g_head
      assign up_v[g]   = in_valid & in_ready;
      assign up_bus[g] = bus_in;
    end else begin : g_body
      assign up_v[g]   = valid_q[g-1];
      assign up_bus[g] = bus_q[g-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (acc[i]) valid_d[i] = up_v[i];
        if (acc[i] && up_v[i]) bus_d[i] = up_bus[i];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) bus_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign {out_tag, out_data, out_lo} = bus_q[DEPTH-1];

`ifdef JIT_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OW'(valid_q[i]);
  end
`endif

endmodule

// File: tb/tb_jit_pipeline_elastic.sv
// Randomized bench for jit_pipeline_elastic against a queue-based model.
// Model tracks each in-flight beat as (position, payload) in FIFO order.
module tb_jit_pipeline_elastic;

  localparam int W = 16;
  localparam int D = 3;
  localparam int L = 8;

  typedef struct packed {
    logic         tag;
    logic [W-1:0] data;
    logic [L-1:0] lo;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   in_op;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic         out_tag;
  logic [W-1:0] out_data;
  logic [L-1:0] out_lo;
`ifdef JIT_PIPE_OCC_EN
  logic [1:0]   occ;
`endif

  jit_pipeline_elastic #(.WIDTH(W), .DEPTH(D), .LO_W(L)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tag  (out_tag),
    .out_data (out_data),
    .out_lo   (out_lo)
`ifdef JIT_PIPE_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  int    pos_q [$];
  beat_t dat_q [$];

  function automatic beat_t model_alu(input int unsigned a,
                                      input int unsigned b,
                                      input int unsigned op);
    beat_t       r;
    int unsigned v;
    case (op)
      0:       v = (a + b) % 65536;
      1:       v = a ^ b;
      2:       v = (a + 65536 - b) % 65536;
      default: v = a & b;
    endcase
    r.tag  = (a == b);
    r.data = v[W-1:0];
    r.lo   = v[L-1:0];
    return r;
  endfunction

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic v, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [1:0] op,
                      input logic rdy, input logic fl);
    logic  exp_rdy, exp_ov;
    beat_t hd;
    int    n;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = rdy;
    flush     = fl;
    #1;
    n       = pos_q.size();
    exp_rdy = !fl && (rdy || n < D);
    exp_ov  = (n > 0) && (pos_q[0] == D - 1);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
`ifdef JIT_PIPE_OCC_EN
    chk("occ", 32'(occ), 32'(n));
`endif
    if (exp_ov) begin
      hd = dat_q[0];
      chk("out_data", 32'(out_data), 32'(hd.data));
      chk("out_tag", 32'(out_tag), 32'(hd.tag));
      chk("out_lo", 32'(out_lo), 32'(hd.lo));
    end
    if (fl) begin
      pos_q.delete();
      dat_q.delete();
    end else begin
      // Beat k moves unless every slot ahead of it is full and the tail stalls.
      for (int k = 0; k < n; k++)
        if (rdy || k != D - 1 - pos_q[k]) pos_q[k]++;
      if (n > 0 && pos_q[0] == D) begin
        void'(pos_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (v && exp_rdy) begin
        pos_q.push_back(0);
        dat_q.push_back(model_alu(a, b, op));
      end
    end
    @(negedge clk);
  endtask

  task automatic rnd_step(input int rdy_pct, input int fl_pct);
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = ($urandom_range(3) == 0) ? a : W'($urandom);
    step($urandom_range(3) != 0, a, b, 2'($urandom),
         $urandom_range(99) < rdy_pct, $urandom_range(99) < fl_pct);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset held with a beat offered
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      in_op = 2'($urandom);
      #1;
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_tag", 32'(out_tag), 0);
      chk("rst_lo", 32'(out_lo), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, wrap, xor-equal
    step(1, 16'h1234, 16'h0101, 2'd0, 1, 0);
    step(1, 16'hFFFF, 16'h0001, 2'd0, 1, 0);
    step(1, 16'h00FF, 16'h00FF, 2'd1, 1, 0);
    step(1, 16'h0000, 16'h0001, 2'd2, 1, 0);
    step(1, 16'hF0F0, 16'h3C3C, 2'd3, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 2'd0, 1, 0);

    // Backpressure: five offers, three accepted, then drain
    for (int i = 0; i < 5; i++)
      step(1, W'(16'h100 + i), W'(i), 2'd0, 0, 0);
    for (int i = 0; i < 2; i++)
      step(1, W'(16'h200 + i), W'(i), 2'd1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, '0, '0, 2'd0, 1, 0);

    // Bubble collapse
    step(1, 16'h0011, 16'h0022, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 2'd0, 0, 0);
    step(1, 16'h0033, 16'h0044, 2'd0, 0, 0);
    step(0, '0, '0, 2'd0, 0, 0);
    step(1, 16'h0055, 16'h0066, 2'd0, 0, 0);
    step(1, 16'h0077, 16'h0088, 2'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 2'd0, 1, 0);

    // Flush with a beat offered, then a clean beat
    for (int i = 0; i < 3; i++)
      step(1, W'(16'h300 + i), 16'h1, 2'd2, 0, 0);
    step(1, 16'hAAAA, 16'h5555, 2'd0, 1, 1);
    step(1, 16'h1111, 16'h2222, 2'd0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 2'd0, 1, 0);

    // Random traffic with varying backpressure
    for (int i = 0; i < 300; i++) rnd_step(70, 4);
    for (int i = 0; i < 200; i++) rnd_step(25, 2);

    // Asynchronous reset in mid-traffic
    for (int i = 0; i < 3; i++)
      step(1, W'($urandom), W'($urandom), 2'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    pos_q.delete();
    dat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) rnd_step(60, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
